result_collector: RTL and testbench

Downstream stage of `dotProduct`: captures each `DotProduct` word qualified by `readEn` and stores it row-major into a DIM×DIM result buffer. Once the buffer holds a full result matrix, it streams the entries out over a valid/ready interface, each tagged with its row/column, then re-arms for the next matrix. It decouples the fixed-rate engine output from a slower consumer (DMA/AXI writer).

---
 rtl/result_collector_pkg.sv | 25 ++
 rtl/result_ram.sv | 27 ++
 rtl/result_collector.sv | 175 +++++++++++++++++
 tb/tb_result_collector.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/result_collector_pkg.sv
// Shared constants, state encoding and width helpers for the dot-product
// result path.
package result_collector_pkg;

   localparam int DEF_DIM       = 10;
   localparam int DEF_RES_WIDTH = 36;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

   // Never returns a zero width, so DIM=1 still gets a legal index bus.
   function automatic int idx_bits(input int v);
      return (v > 1) ? clog2(v) : 1;
   endfunction

endpackage

// File: rtl/result_ram.sv
// Simple dual-port result buffer: one write port and one registered read port.
// The read register has no reset so the array maps onto block RAM.
module result_ram #(
   parameter int DEPTH = 100,
   parameter int WIDTH = 36,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/result_collector.sv
// Collects DIM*DIM engine results into a buffer and streams them out row-major
// over valid/ready, tagging each entry with its row and column.
module result_collector
   import result_collector_pkg::*;
#(
   parameter int DIM       = DEF_DIM,
   parameter int RES_WIDTH = DEF_RES_WIDTH,
   parameter int IDX_WIDTH = idx_bits(DIM)
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 clear,
   input  logic                 readEn,
   input  logic [RES_WIDTH-1:0] DotProduct,
   output logic [RES_WIDTH-1:0] outData,
   output logic [IDX_WIDTH-1:0] outRow,
   output logic [IDX_WIDTH-1:0] outCol,
   output logic                 outValid,
   input  logic                 outReady,
   output logic                 matrixDone,
   output logic                 overflow
);

   localparam int                 DEPTH     = DIM * DIM;
   localparam int                 AW        = idx_bits(DEPTH);
   localparam logic [AW-1:0]      LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DIM - 1);

   state_e                 state_q, state_d;
   logic [IDX_WIDTH-1:0]   wr_row_q, wr_row_d, wr_col_q, wr_col_d;
   logic [AW-1:0]          wr_addr_q, wr_addr_d;
   logic [IDX_WIDTH-1:0]   rd_row_q, rd_row_d, rd_col_q, rd_col_d;
   logic [AW-1:0]          rd_addr_q, rd_addr_d;
   logic                   rd_busy_q, rd_busy_d;
   logic                   pend_q, pend_d;
   logic [IDX_WIDTH-1:0]   pend_row_q, pend_row_d, pend_col_q, pend_col_d;
   logic [RES_WIDTH-1:0]   h_data_q, h_data_d, t_data_q, t_data_d;
   logic [IDX_WIDTH-1:0]   h_row_q, h_row_d, h_col_q, h_col_d;
   logic [IDX_WIDTH-1:0]   t_row_q, t_row_d, t_col_q, t_col_d;
   logic [1:0]             cnt_q, cnt_d;
   logic                   done_q, done_d, ovf_q, ovf_d;

   logic                   wr_hit, last_cap, pop, last_pop, rd_issue;
   logic [2:0]             occ;
   logic [RES_WIDTH-1:0]   ram_rdata;

   result_ram #(.DEPTH(DEPTH), .WIDTH(RES_WIDTH), .AW(AW)) u_ram (
      .clk   (Clock),
      .we    (wr_hit),
      .waddr (wr_addr_q),
      .wdata (DotProduct),
      .re    (rd_issue),
      .raddr (rd_addr_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d    = state_q;
      wr_row_d   = wr_row_q;   wr_col_d = wr_col_q;   wr_addr_d = wr_addr_q;
      rd_row_d   = rd_row_q;   rd_col_d = rd_col_q;   rd_addr_d = rd_addr_q;
      rd_busy_d  = rd_busy_q;
      pend_d     = 1'b0;
      pend_row_d = pend_row_q; pend_col_d = pend_col_q;
      h_data_d   = h_data_q;   h_row_d = h_row_q;     h_col_d = h_col_q;
      t_data_d   = t_data_q;   t_row_d = t_row_q;     t_col_d = t_col_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;

      wr_hit   = (state_q == FILL) && readEn;
      last_cap = wr_hit && (wr_addr_q == LAST_ADDR);
      pop      = (cnt_q != 2'd0) && outReady;
      last_pop = pop && (h_row_q == LAST_IDX) && (h_col_q == LAST_IDX);
      // Occupancy the skid buffer will have once this cycle's push/pop settle;
      // a read issued now lands one cycle later and must still fit.
      occ      = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
      rd_issue = (last_cap || ((state_q == DRAIN) && rd_busy_q)) && (occ < 3'd2);

      if (wr_hit) begin
         wr_addr_d = wr_addr_q + 1'b1;
         if (wr_col_q == LAST_IDX) begin
            wr_col_d = '0;
            wr_row_d = wr_row_q + 1'b1;
         end else begin
            wr_col_d = wr_col_q + 1'b1;
         end
      end
      if (last_cap) begin
         state_d  = DRAIN;
         wr_row_d = '0; wr_col_d = '0; wr_addr_d = '0;
         done_d   = 1'b1;
      end
      if ((state_q == DRAIN) && readEn) ovf_d = 1'b1;

      // Address 0 is read on the last capture edge so data is ready right
      // after the matrixDone cycle.
      if (rd_issue) begin
         pend_d     = 1'b1;
         pend_row_d = rd_row_q;
         pend_col_d = rd_col_q;
         rd_busy_d  = (rd_addr_q != LAST_ADDR);
         rd_addr_d  = rd_addr_q + 1'b1;
         if (rd_col_q == LAST_IDX) begin
            rd_col_d = '0;
            rd_row_d = rd_row_q + 1'b1;
         end else begin
            rd_col_d = rd_col_q + 1'b1;
         end
      end

      if (pop) begin
         if (cnt_q == 2'd2) begin
            h_data_d = t_data_q; h_row_d = t_row_q; h_col_d = t_col_q;
            if (pend_q) begin
               t_data_d = ram_rdata; t_row_d = pend_row_q; t_col_d = pend_col_q;
            end else begin
               cnt_d = 2'd1;
            end
         end else if (pend_q) begin
            h_data_d = ram_rdata; h_row_d = pend_row_q; h_col_d = pend_col_q;
         end else begin
            cnt_d = 2'd0;
         end
      end else if (pend_q) begin
         if (cnt_q == 2'd0) begin
            h_data_d = ram_rdata; h_row_d = pend_row_q; h_col_d = pend_col_q;
            cnt_d    = 2'd1;
         end else begin
            t_data_d = ram_rdata; t_row_d = pend_row_q; t_col_d = pend_col_q;
            cnt_d    = 2'd2;
         end
      end

      if (last_pop) begin
         state_d  = FILL;
         rd_row_d = '0; rd_col_d = '0; rd_addr_d = '0; rd_busy_d = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset || clear) begin
         state_q    <= FILL;
         wr_row_q   <= '0; wr_col_q <= '0; wr_addr_q <= '0;
         rd_row_q   <= '0; rd_col_q <= '0; rd_addr_q <= '0;
         rd_busy_q  <= 1'b0;
         pend_q     <= 1'b0;
         pend_row_q <= '0; pend_col_q <= '0;
         h_data_q   <= '0; h_row_q <= '0; h_col_q <= '0;
         t_data_q   <= '0; t_row_q <= '0; t_col_q <= '0;
         cnt_q      <= 2'd0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_row_q   <= wr_row_d; wr_col_q <= wr_col_d; wr_addr_q <= wr_addr_d;
         rd_row_q   <= rd_row_d; rd_col_q <= rd_col_d; rd_addr_q <= rd_addr_d;
         rd_busy_q  <= rd_busy_d;
         pend_q     <= pend_d;
         pend_row_q <= pend_row_d; pend_col_q <= pend_col_d;
         h_data_q   <= h_data_d; h_row_q <= h_row_d; h_col_q <= h_col_d;
         t_data_q   <= t_data_d; t_row_q <= t_row_d; t_col_q <= t_col_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign outData    = h_data_q;
   assign outRow     = h_row_q;
   assign outCol     = h_col_q;
   assign outValid   = (cnt_q != 2'd0);
   assign matrixDone = done_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_result_collector.sv
// Randomized and directed bench for result_collector (DIM=2) checked against a
// queue-based model of fill / drain behaviour.
module tb_result_collector;

   localparam int DIM = 2;
   localparam int RW  = 36;
   localparam int IW  = 1;

   logic          clk = 1'b0;
   logic          Reset = 1'b1, clear = 1'b0, readEn = 1'b0, outReady = 1'b0;
   logic [RW-1:0] DotProduct = '0;
   logic [RW-1:0] outData;
   logic [IW-1:0] outRow, outCol;
   logic          outValid, matrixDone, overflow;

   result_collector #(.DIM(DIM), .RES_WIDTH(RW), .IDX_WIDTH(IW)) dut (
      .Clock(clk), .Reset(Reset), .clear(clear), .readEn(readEn),
      .DotProduct(DotProduct), .outData(outData), .outRow(outRow),
      .outCol(outCol), .outValid(outValid), .outReady(outReady),
      .matrixDone(matrixDone), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   bit chk_en = 1'b0;

   // Model: words gathered so far, words still owed to the consumer.
   logic [RW-1:0] fillq[$], outq[$];
   bit drain = 1'b0, ovf_m = 1'b0, done_m = 1'b0;
   int since = 0;

   logic [RW-1:0] va[4];
   logic [RW-1:0] vb[4];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic cyc(input bit re, input logic [RW-1:0] d, input bit rdy,
                      input bit rst, input bit clr);
      bit exp_valid;
      int idx;
      @(negedge clk);
      exp_valid = drain && (since >= 1) && (outq.size() > 0);
      if (chk_en) begin
         chk("outValid", 64'(outValid), 64'(exp_valid));
         chk("matrixDone", 64'(matrixDone), 64'(done_m));
         chk("overflow", 64'(overflow), 64'(ovf_m));
         if (exp_valid && outValid) begin
            idx = DIM * DIM - outq.size();
            chk("outData", 64'(outData), 64'(outq[0]));
            chk("outRow", 64'(outRow), 64'(idx / DIM));
            chk("outCol", 64'(outCol), 64'(idx % DIM));
         end
      end
      readEn = re; DotProduct = d; outReady = rdy; Reset = rst; clear = clr;
      done_m = 1'b0;
      if (rst || clr) begin
         drain = 1'b0; ovf_m = 1'b0; since = 0;
         fillq.delete(); outq.delete();
      end else if (drain) begin
         since++;
         if (re) ovf_m = 1'b1;
         if (exp_valid && rdy) begin
            void'(outq.pop_front());
            if (outq.size() == 0) drain = 1'b0;
         end
      end else if (re) begin
         fillq.push_back(d);
         if (fillq.size() == DIM * DIM) begin
            outq = fillq;
            fillq.delete();
            drain = 1'b1; since = 0; done_m = 1'b1;
         end
      end
   endtask

   task automatic fill4(input logic [RW-1:0] w0, input logic [RW-1:0] w1,
                        input logic [RW-1:0] w2, input logic [RW-1:0] w3);
      cyc(1'b1, w0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, w1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, w2, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, w3, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      va[0] = 36'd640;        va[1] = 36'd13669466157;
      va[2] = 36'd8030888999; va[3] = 36'd11518131799;
      vb[0] = 36'({$urandom, $urandom}); vb[1] = 36'({$urandom, $urandom});
      vb[2] = 36'({$urandom, $urandom}); vb[3] = 36'({$urandom, $urandom});

      // Reset held three cycles; outputs must be zero once it has taken effect.
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk_en = 1'b1;
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("rst_outData", 64'(outData), 64'd0);
      chk("rst_outRow", 64'(outRow), 64'd0);
      chk("rst_outCol", 64'(outCol), 64'd0);

      // Full-rate drain.
      fill4(va[0], va[1], va[2], va[3]);
      for (int k = 0; k < 8; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Alternating back-pressure.
      fill4(va[0], va[1], va[2], va[3]);
      for (int k = 0; k < 14; k++) cyc(1'b0, '0, k[0], 1'b0, 1'b0);

      // Word arriving during drain is dropped and flagged.
      fill4(va[0], va[1], va[2], va[3]);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 36'd8092373917, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 14; k++) cyc(1'b0, '0, k[0], 1'b0, 1'b0);

      // Reset mid-fill discards the partial matrix.
      cyc(1'b1, 36'd9521434271, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 36'd7178516105, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      fill4(vb[0], vb[1], vb[2], vb[3]);
      for (int k = 0; k < 8; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // clear after the second handshake, then a fresh matrix.
      fill4(va[3], va[2], va[1], va[0]);
      for (int k = 0; k < 20 && outq.size() > 2; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      fill4(vb[3], vb[2], vb[1], vb[0]);
      for (int k = 0; k < 8; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Random traffic with occasional clear.
      for (int k = 0; k < 600; k++)
         cyc(bit'($urandom_range(0, 1)), 36'({$urandom, $urandom}),
             bit'($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 79) == 0));
      for (int k = 0; k < 8; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
